// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-select and HI/LO source codes.
package wb_stage_pkg;

  typedef enum logic [3:0] {
    MTR_ALU = 4'd0,
    MTR_LW  = 4'd1,
    MTR_LB  = 4'd2,
    MTR_LBU = 4'd3,
    MTR_LH  = 4'd4,
    MTR_LHU = 4'd5,
    MTR_LWL = 4'd6,
    MTR_LWR = 4'd7,
    MTR_HI  = 4'd8,
    MTR_LO  = 4'd9
  } mtr_e;

  // Code 2'b11 is deliberately unnamed: it behaves like HL_NONE.
  typedef enum logic [1:0] {
    HL_NONE = 2'd0,
    HL_RES  = 2'd1,
    HL_RS   = 2'd2
  } hl_sel_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handover bundle: valid/allowin handshake plus the instruction payload and load data.
interface wb_stage_if;
  logic        MEM_to_WB_valid;
  logic        WB_allowin;
  logic [31:0] PC_MEM;
  logic [31:0] Instruction_MEM;
  logic [3:0]  rf_wen_MEM;
  logic [4:0]  rf_waddr_MEM;
  logic [3:0]  MemtoReg_MEM;
  logic [1:0]  Byte_MEM;
  logic [31:0] rf_wdata_temp_MEM;
  logic [31:0] data_sram_rdata;
  logic        HI_write_MEM;
  logic        LO_write_MEM;
  logic [1:0]  HI_MemtoReg_MEM;
  logic [1:0]  LO_MemtoReg_MEM;
  logic [31:0] HI_wdata_MEM;
  logic [31:0] LO_wdata_MEM;

  modport master (
    output MEM_to_WB_valid, PC_MEM, Instruction_MEM, rf_wen_MEM, rf_waddr_MEM,
           MemtoReg_MEM, Byte_MEM, rf_wdata_temp_MEM, data_sram_rdata,
           HI_write_MEM, LO_write_MEM, HI_MemtoReg_MEM, LO_MemtoReg_MEM,
           HI_wdata_MEM, LO_wdata_MEM,
    input  WB_allowin
  );

  modport slave (
    input  MEM_to_WB_valid, PC_MEM, Instruction_MEM, rf_wen_MEM, rf_waddr_MEM,
           MemtoReg_MEM, Byte_MEM, rf_wdata_temp_MEM, data_sram_rdata,
           HI_write_MEM, LO_write_MEM, HI_MemtoReg_MEM, LO_MemtoReg_MEM,
           HI_wdata_MEM, LO_wdata_MEM,
    output WB_allowin
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks/extends the addressed byte or halfword, or shifts for LWL/LWR.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [3:0]  mtr_i,
  input  logic [1:0]  byte_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic signed [7:0]  lb;
  logic signed [15:0] lh;
  logic [4:0]         sh_r;
  logic [4:0]         sh_l;

  always_comb begin
    sh_r = {byte_i, 3'b000};
    // 8*(3-b) == 8*~b for a 2-bit offset
    sh_l = {~byte_i, 3'b000};
    lb   = rdata_i[sh_r +: 8];
    // Halfword lane comes from b[1] alone; misalignment is trapped before WB.
    lh   = byte_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mtr_i)
      MTR_LB:  data_o = 32'(lb);
      MTR_LBU: data_o = {24'b0, lb};
      MTR_LH:  data_o = 32'(lh);
      MTR_LHU: data_o = {16'b0, lh};
      MTR_LWL: data_o = rdata_i << sh_l;
      MTR_LWR: data_o = rdata_i >> sh_r;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: captures the MEM bundle, drives the RF write port and trace, owns HI/LO.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   mem_wb,
  output logic        WB_valid,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ready_go;
  logic        accept;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [3:0]  rf_wen_q;
  logic [4:0]  rf_waddr_q;
  logic [3:0]  mtr_q;
  logic [1:0]  byte_q;
  logic [31:0] temp_q;
  logic [31:0] rdata_q;
  logic        hi_write_q, lo_write_q;
  logic [1:0]  hi_sel_q, lo_sel_q;
  logic [31:0] hi_wdata_q, lo_wdata_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_d, lo_d;
  logic [31:0] load_data;

  // Instruction word is carried for trace only and is not consumed here.
  logic        unused_inst;
  assign unused_inst = ^mem_wb.Instruction_MEM;

  assign ready_go          = 1'b1;
  assign mem_wb.WB_allowin = !valid_q || ready_go;
  assign accept            = mem_wb.MEM_to_WB_valid && mem_wb.WB_allowin;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (valid_q && hi_write_q) begin
      case (hi_sel_q)
        HL_RES:  hi_d = hi_wdata_q;
        HL_RS:   hi_d = temp_q;
        default: hi_d = hi_q;
      endcase
    end
    if (valid_q && lo_write_q) begin
      case (lo_sel_q)
        HL_RES:  lo_d = lo_wdata_q;
        HL_RS:   lo_d = temp_q;
        default: lo_d = lo_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rf_wen_q   <= '0;
      rf_waddr_q <= '0;
      mtr_q      <= '0;
      byte_q     <= '0;
      temp_q     <= '0;
      rdata_q    <= '0;
      hi_write_q <= 1'b0;
      lo_write_q <= 1'b0;
      hi_sel_q   <= '0;
      lo_sel_q   <= '0;
      hi_wdata_q <= '0;
      lo_wdata_q <= '0;
      hi_q       <= HILO_RST;
      lo_q       <= HILO_RST;
    end else begin
      if (mem_wb.WB_allowin) valid_q <= mem_wb.MEM_to_WB_valid;
      if (accept) begin
        pc_q       <= mem_wb.PC_MEM;
        rf_wen_q   <= mem_wb.rf_wen_MEM;
        rf_waddr_q <= mem_wb.rf_waddr_MEM;
        mtr_q      <= mem_wb.MemtoReg_MEM;
        byte_q     <= mem_wb.Byte_MEM;
        temp_q     <= mem_wb.rf_wdata_temp_MEM;
        rdata_q    <= mem_wb.data_sram_rdata;
        hi_write_q <= mem_wb.HI_write_MEM;
        lo_write_q <= mem_wb.LO_write_MEM;
        hi_sel_q   <= mem_wb.HI_MemtoReg_MEM;
        lo_sel_q   <= mem_wb.LO_MemtoReg_MEM;
        hi_wdata_q <= mem_wb.HI_wdata_MEM;
        lo_wdata_q <= mem_wb.LO_wdata_MEM;
      end
      // HI/LO commit at the end of the WB cycle, so a following MFHI/MFLO sees the new value.
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  wb_stage_load_align u_load_align (
    .mtr_i   (mtr_q),
    .byte_i  (byte_q),
    .rdata_i (rdata_q),
    .data_o  (load_data)
  );

  always_comb begin
    case (mtr_q)
      MTR_ALU: rf_wdata = temp_q;
      MTR_LW, MTR_LB, MTR_LBU, MTR_LH,
      MTR_LHU, MTR_LWL, MTR_LWR:
               rf_wdata = load_data;
      MTR_HI:  rf_wdata = hi_q;
      MTR_LO:  rf_wdata = lo_q;
      default: rf_wdata = temp_q;
    endcase
  end

  assign WB_valid          = valid_q;
  assign rf_we             = rf_wen_q & {4{valid_q}};
  assign rf_waddr          = rf_waddr_q;
  assign HI_out            = hi_q;
  assign LO_out            = lo_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load alignment table, HI/LO sequencing, bubbles and mid-stream reset.
module tb_wb_stage;

  localparam logic [31:0] RST_HL = 32'hA5A5_0F0F;

  logic        clk;
  logic        resetn;
  logic        WB_valid;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] HI_out, LO_out;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks   = 0;
  int failures = 0;

  wb_stage_if bus ();

  wb_stage #(.HILO_RST(RST_HL)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_wb            (bus),
    .WB_valid          (WB_valid),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .HI_out            (HI_out),
    .LO_out            (LO_out),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mtr;
    logic [1:0]  b;
    logic [31:0] r;
    logic [31:0] temp;
    logic [3:0]  wen;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] mtr, input logic [1:0] b,
                       input logic [31:0] r, input logic [31:0] temp, input logic [3:0] wen,
                       input logic [4:0] waddr, input logic [31:0] pc);
    bus.MEM_to_WB_valid   = v;
    bus.MemtoReg_MEM      = mtr;
    bus.Byte_MEM          = b;
    bus.data_sram_rdata   = r;
    bus.rf_wdata_temp_MEM = temp;
    bus.rf_wen_MEM        = wen;
    bus.rf_waddr_MEM      = waddr;
    bus.PC_MEM            = pc;
    bus.Instruction_MEM   = pc ^ 32'h1357_9BDF;
    bus.HI_write_MEM      = 1'b0;
    bus.LO_write_MEM      = 1'b0;
    bus.HI_MemtoReg_MEM   = 2'b00;
    bus.LO_MemtoReg_MEM   = 2'b00;
    bus.HI_wdata_MEM      = 32'h0;
    bus.LO_wdata_MEM      = 32'h0;
  endtask

  task automatic hilo(input logic hw, input logic [1:0] hs, input logic [31:0] hd,
                      input logic lw, input logic [1:0] ls, input logic [31:0] ld);
    bus.HI_write_MEM    = hw;
    bus.HI_MemtoReg_MEM = hs;
    bus.HI_wdata_MEM    = hd;
    bus.LO_write_MEM    = lw;
    bus.LO_MemtoReg_MEM = ls;
    bus.LO_wdata_MEM    = ld;
  endtask

  initial begin
    //              mtr    b     rdata          temp           wen      expected
    vecs[0]  = '{4'd2, 2'd2, 32'h80FF_7F01, 32'h0,         4'hF,    32'hFFFF_FFFF}; // LB
    vecs[1]  = '{4'd3, 2'd3, 32'h80FF_7F01, 32'h0,         4'hF,    32'h0000_0080}; // LBU
    vecs[2]  = '{4'd4, 2'd2, 32'h8001_1234, 32'h0,         4'hF,    32'hFFFF_8001}; // LH
    vecs[3]  = '{4'd5, 2'd0, 32'h8001_1234, 32'h0,         4'hF,    32'h0000_1234}; // LHU
    vecs[4]  = '{4'd6, 2'd1, 32'hAABB_CCDD, 32'h0,         4'b1100, 32'hCCDD_0000}; // LWL
    vecs[5]  = '{4'd7, 2'd1, 32'hAABB_CCDD, 32'h0,         4'b0111, 32'h00AA_BBCC}; // LWR
    vecs[6]  = '{4'd1, 2'd0, 32'hDEAD_BEEF, 32'h0,         4'hF,    32'hDEAD_BEEF}; // LW
    vecs[7]  = '{4'd0, 2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF,    32'h1234_5678}; // ALU
    vecs[8]  = '{4'd4, 2'd3, 32'h8001_1234, 32'h0,         4'hF,    32'hFFFF_8001}; // LH b0 ignored
    vecs[9]  = '{4'd2, 2'd0, 32'h80FF_7F01, 32'h0,         4'hF,    32'h0000_0001}; // LB lane 0
    vecs[10] = '{4'd6, 2'd3, 32'hAABB_CCDD, 32'h0,         4'hF,    32'hAABB_CCDD}; // LWL full
    vecs[11] = '{4'd6, 2'd0, 32'hAABB_CCDD, 32'h0,         4'b1000, 32'hDD00_0000}; // LWL 1 byte
    vecs[12] = '{4'd7, 2'd3, 32'hAABB_CCDD, 32'h0,         4'b0001, 32'h0000_00AA}; // LWR 1 byte
    vecs[13] = '{4'd8, 2'd0, 32'h0,         32'h0,         4'hF,    RST_HL};        // MFHI reset
    vecs[14] = '{4'd9, 2'd0, 32'h0,         32'h0,         4'hF,    RST_HL};        // MFLO reset
    vecs[15] = '{4'hF, 2'd1, 32'h1111_1111, 32'hCAFE_F00D, 4'h3,    32'hCAFE_F00D}; // unused code
    vecs[16] = '{4'd5, 2'd2, 32'hF00D_8001, 32'h0,         4'hF,    32'h0000_F00D}; // LHU upper

    resetn = 1'b0;
    drive(1'b0, 4'd0, 2'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    step();
    step();
    chk("rst_valid", {31'b0, WB_valid}, 32'h0);
    chk("rst_allowin", {31'b0, bus.WB_allowin}, 32'h1);
    chk("rst_rf_we", {28'b0, rf_we}, 32'h0);
    chk("rst_dbg_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);
    chk("rst_dbg_wnum", {27'b0, debug_wb_rf_wnum}, 32'h0);
    chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rst_hi", HI_out, RST_HL);
    chk("rst_lo", LO_out, RST_HL);
    resetn = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].mtr, vecs[i].b, vecs[i].r, vecs[i].temp, vecs[i].wen,
            5'(i + 1), 32'hBFC0_0000 + 32'(i * 4));
      step();
      chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp);
      chk($sformatf("v%0d_we", i), {28'b0, rf_we}, {28'b0, vecs[i].wen});
      chk($sformatf("v%0d_dbg_wen", i), {28'b0, debug_wb_rf_wen}, {28'b0, vecs[i].wen});
      chk($sformatf("v%0d_dbg_wdata", i), debug_wb_rf_wdata, vecs[i].exp);
      chk($sformatf("v%0d_waddr", i), {27'b0, rf_waddr}, 32'(i + 1));
      chk($sformatf("v%0d_pc", i), debug_wb_pc, 32'hBFC0_0000 + 32'(i * 4));
    end

    // MULT writes HI=1, LO=2; not visible until its WB cycle ends
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'hBFC0_0100);
    hilo(1'b1, 2'b01, 32'h1, 1'b1, 2'b01, 32'h2);
    step();
    chk("mult_valid", {31'b0, WB_valid}, 32'h1);
    chk("mult_hi_pre", HI_out, RST_HL);
    // MTHI 0x55
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h55, 4'h0, 5'd0, 32'hBFC0_0104);
    hilo(1'b1, 2'b10, 32'h0, 1'b0, 2'b00, 32'h0);
    step();
    chk("mult_hi", HI_out, 32'h1);
    chk("mult_lo", LO_out, 32'h2);
    // MFHI right after MTHI
    drive(1'b1, 4'd8, 2'd0, 32'h0, 32'h0, 4'hF, 5'd9, 32'hBFC0_0108);
    step();
    chk("mfhi_wdata", rf_wdata, 32'h55);
    chk("mfhi_we", {28'b0, rf_we}, 32'hF);
    chk("mthi_lo_kept", LO_out, 32'h2);
    // MFLO carrying select 11 on both: must hold
    drive(1'b1, 4'd9, 2'd0, 32'h0, 32'h99, 4'hF, 5'd10, 32'hBFC0_010C);
    hilo(1'b1, 2'b11, 32'hDEAD_DEAD, 1'b1, 2'b11, 32'hBEEF_BEEF);
    step();
    chk("mflo_wdata", rf_wdata, 32'h2);
    // MTLO 0x77 with HI select 00
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h77, 4'h0, 5'd0, 32'hBFC0_0110);
    hilo(1'b1, 2'b00, 32'hDEAD_0000, 1'b1, 2'b10, 32'h0);
    step();
    chk("sel11_hi_hold", HI_out, 32'h55);
    chk("sel11_lo_hold", LO_out, 32'h2);
    // Bubble with stale write requests
    drive(1'b0, 4'd0, 2'd0, 32'h0, 32'h0, 4'hF, 5'd3, 32'hBFC0_0114);
    hilo(1'b1, 2'b01, 32'hDEAD_BEEF, 1'b1, 2'b01, 32'hDEAD_BEEF);
    step();
    chk("mtlo_lo", LO_out, 32'h77);
    chk("sel00_hi_hold", HI_out, 32'h55);
    chk("bub_valid", {31'b0, WB_valid}, 32'h0);
    chk("bub_rf_we", {28'b0, rf_we}, 32'h0);
    chk("bub_dbg_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
    step();
    chk("bub_hi", HI_out, 32'h55);
    chk("bub_lo", LO_out, 32'h77);

    // Valid LW in WB, then reset mid-stream
    drive(1'b1, 4'd1, 2'd0, 32'h1111_2222, 32'h0, 4'hF, 5'd4, 32'hBFC0_0200);
    hilo(1'b1, 2'b01, 32'h0BAD_0BAD, 1'b1, 2'b01, 32'h0BAD_0BAD);
    step();
    chk("lw_valid", {31'b0, WB_valid}, 32'h1);
    chk("lw_wdata", rf_wdata, 32'h1111_2222);
    resetn = 1'b0;
    drive(1'b0, 4'd0, 2'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0);
    step();
    chk("mrst_valid", {31'b0, WB_valid}, 32'h0);
    chk("mrst_rf_we", {28'b0, rf_we}, 32'h0);
    chk("mrst_hi", HI_out, RST_HL);
    chk("mrst_lo", LO_out, RST_HL);
    chk("mrst_dbg_pc", debug_wb_pc, 32'h0);
    resetn = 1'b1;
    step();
    drive(1'b1, 4'd3, 2'd1, 32'h0000_F300, 32'h0, 4'hF, 5'd7, 32'hBFC0_0300);
    step();
    chk("post_rst_lbu", rf_wdata, 32'h0000_00F3);
    chk("post_rst_we", {28'b0, rf_we}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
